// File: rtl/scr1_tb_ahb_mem_pkg.sv
// Shared types and helpers for the parametrised AHB-Lite memory slave.
// The AHB htrans/hsize encodings mirror those of scr1_ahb.svh.
package scr1_tb_ahb_mem_pkg;

    localparam logic [1:0] SCR1_HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] SCR1_HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] SCR1_HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] SCR1_HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] SCR1_HSIZE_8BIT  = 3'b000;
    localparam logic [2:0] SCR1_HSIZE_16BIT = 3'b001;
    localparam logic [2:0] SCR1_HSIZE_32BIT = 3'b010;
    localparam logic [2:0] SCR1_HSIZE_64BIT = 3'b011;

    // x^16 + x^14 + x^13 + x^11 + 1, state bit k holds tap k+1
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } state_e;

    typedef enum logic [1:0] {
        STALL_NONE     = 2'd0,
        STALL_FIXED    = 2'd1,
        STALL_RANDOM   = 2'd2,
        STALL_NONE_ALT = 2'd3
    } stall_mode_e;

    function automatic logic [7:0] size_to_be(input logic [2:0] hsize, input logic [2:0] addr_lsb);
        logic [7:0] mask;
        case (hsize)
            SCR1_HSIZE_8BIT:  mask = 8'h01;
            SCR1_HSIZE_16BIT: mask = 8'h03;
            SCR1_HSIZE_32BIT: mask = 8'h0F;
            default:          mask = 8'hFF;
        endcase
        return mask << addr_lsb;
    endfunction

endpackage

// File: rtl/scr1_tb_lfsr16.sv
// 16-bit Fibonacci LFSR used to draw random wait-state counts.
module scr1_tb_lfsr16
    import scr1_tb_ahb_mem_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [15:0] state
);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SEED;
        end else if (en) begin
            state <= {state[14:0], ^(state & LFSR_TAPS)};
        end
    end

endmodule

// File: rtl/scr1_tb_ahb_mem_slave.sv
// AHB-Lite memory slave with selectable wait states, two-cycle ERROR
// responses for illegal accesses and transfer/error counters.
module scr1_tb_ahb_mem_slave
    import scr1_tb_ahb_mem_pkg::*;
#(
    parameter int                DATA_W    = 32,
    parameter int                ADDR_W    = 32,
    parameter int                MEM_BYTES = 65536,
    parameter int                STALL_W   = 4,
    parameter logic [15:0]       LFSR_SEED = 16'hACE1,
    parameter logic [ADDR_W-1:0] ERR_BASE  = 32'hFFFF_0000,
    parameter int unsigned       ERR_SIZE  = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         stall_mode,
    input  logic [STALL_W-1:0] stall_cnt,
    input  logic [1:0]         htrans,
    input  logic [2:0]         hsize,
    input  logic [ADDR_W-1:0]  haddr,
    input  logic               hwrite,
    input  logic [DATA_W-1:0]  hwdata,
    output logic               hready,
    output logic [DATA_W-1:0]  hrdata,
    output logic               hresp,
    output logic [31:0]        txn_cnt,
    output logic [15:0]        err_cnt
);

    localparam int BYTES = DATA_W / 8;
    localparam int BW    = $clog2(BYTES);
    localparam int MEM_W = $clog2(MEM_BYTES);

    localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W+1)'(MEM_BYTES);
    localparam logic [ADDR_W:0] ERR_LO    = {1'b0, ERR_BASE};
    localparam logic [ADDR_W:0] ERR_HI    = ERR_LO + (ADDR_W+1)'(ERR_SIZE);

    state_e             state_q, state_d;
    logic [STALL_W-1:0] cnt_q, cnt_d;
    logic [STALL_W-1:0] stall_load;
    logic [15:0]        lfsr_state;

    logic [MEM_W-1:0]   addr_p1;
    logic [2:0]         size_p1;
    logic               write_p1;

    logic [7:0]         mem [MEM_BYTES];

    logic               ready_st;
    logic               accept;
    logic               illegal;
    logic [2:0]         lsb_mask;
    logic [7:0]         be_full;
    logic [BYTES-1:0]   be;
    logic [MEM_W-1:0]   word_base;
    logic               unused_bits;

    scr1_tb_lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .en    (stall_mode == STALL_RANDOM),
        .state (lfsr_state)
    );

    assign ready_st = (state_q == ST_IDLE) || (state_q == ST_DATA) || (state_q == ST_ERR2);
    assign accept   = ready_st && ((htrans == SCR1_HTRANS_NONSEQ) || (htrans == SCR1_HTRANS_SEQ));

    always_comb begin
        case (hsize)
            SCR1_HSIZE_8BIT:  lsb_mask = 3'b000;
            SCR1_HSIZE_16BIT: lsb_mask = 3'b001;
            SCR1_HSIZE_32BIT: lsb_mask = 3'b011;
            default:          lsb_mask = 3'b111;
        endcase
        illegal = (hsize > 3'(BW))
               || (|(haddr[2:0] & lsb_mask))
               || ({1'b0, haddr} >= MEM_LIMIT)
               || ((ERR_SIZE != 0) && ({1'b0, haddr} >= ERR_LO) && ({1'b0, haddr} < ERR_HI));
    end

    always_comb begin
        case (stall_mode)
            STALL_FIXED:  stall_load = stall_cnt;
            STALL_RANDOM: stall_load = lfsr_state[STALL_W-1:0] & stall_cnt;
            default:      stall_load = '0;
        endcase
    end

    // Next state: outputs depend on state_q only, so hready has no input path
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hready  = ready_st;
        hresp   = (state_q == ST_ERR1) || (state_q == ST_ERR2);
        case (state_q)
            ST_WAIT: begin
                cnt_d = cnt_q - STALL_W'(1);
                if (cnt_q == STALL_W'(1)) state_d = ST_DATA;
            end
            ST_ERR1: state_d = ST_ERR2;
            default: ;
        endcase
        if (ready_st) begin
            if (!accept) begin
                state_d = ST_IDLE;
            end else if (illegal) begin
                state_d = ST_ERR1;
            end else if (stall_load == '0) begin
                state_d = ST_DATA;
            end else begin
                state_d = ST_WAIT;
                cnt_d   = stall_load;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Address phase -> data phase registers
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_p1  <= haddr[MEM_W-1:0];
            size_p1  <= hsize;
            write_p1 <= hwrite;
        end
    end

    assign be_full     = size_to_be(size_p1, 3'(addr_p1[BW-1:0]));
    assign be          = be_full[BYTES-1:0];
    assign word_base   = addr_p1 & ~MEM_W'(BYTES - 1);
    assign unused_bits = ^{lfsr_state, be_full};

    // Data phase: write commits on the edge that closes the DATA cycle
    always_ff @(posedge clk) begin
        if (!rst && (state_q == ST_DATA) && write_p1) begin
            for (int i = 0; i < BYTES; i++) begin
                if (be[i]) mem[word_base | MEM_W'(i)] <= hwdata[8*i +: 8];
            end
        end
    end

    always_comb begin
        hrdata = '0;
        if ((state_q == ST_DATA) && !write_p1) begin
            for (int i = 0; i < BYTES; i++) begin
                hrdata[8*i +: 8] = mem[word_base | MEM_W'(i)];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            txn_cnt <= '0;
            err_cnt <= '0;
        end else begin
            if ((state_q == ST_DATA) && (txn_cnt != '1)) txn_cnt <= txn_cnt + 32'd1;
            if ((state_q == ST_ERR2) && (err_cnt != '1)) err_cnt <= err_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_scr1_tb_ahb_mem_slave.sv
// Scoreboard bench for scr1_tb_ahb_mem_slave: expected responses are queued
// when a transfer is issued and compared when its data phase completes.
module tb_scr1_tb_ahb_mem_slave;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  stall_mode;
    logic [3:0]  stall_cnt;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic [31:0] haddr;
    logic        hwrite;
    logic [31:0] hwdata;
    logic        hready;
    logic [31:0] hrdata;
    logic        hresp;
    logic [31:0] txn_cnt;
    logic [15:0] err_cnt;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] data;
        int          waits;
        logic        err;
    } exp_t;

    typedef struct {
        logic [31:0] data;
        int          waits;
        logic        resp_first;
        logic        resp_last;
    } obs_t;

    typedef struct {
        logic        w;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
    } op_t;

    exp_t        exp_q[$];
    logic [7:0]  model_mem [int unsigned];
    int          rand_seq [2][200];

    scr1_tb_ahb_mem_slave #(
        .DATA_W    (32),
        .ADDR_W    (32),
        .MEM_BYTES (65536),
        .STALL_W   (4),
        .LFSR_SEED (16'hACE1),
        .ERR_BASE  (32'h0000_F000),
        .ERR_SIZE  (256)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .stall_mode (stall_mode),
        .stall_cnt  (stall_cnt),
        .htrans     (htrans),
        .hsize      (hsize),
        .haddr      (haddr),
        .hwrite     (hwrite),
        .hwdata     (hwdata),
        .hready     (hready),
        .hrdata     (hrdata),
        .hresp      (hresp),
        .txn_cnt    (txn_cnt),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void model_write(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d);
        for (int b = 0; b < (1 << sz); b++) begin
            int unsigned ba = a + b;
            model_mem[ba] = d[8*(ba % 4) +: 8];
        end
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        logic [31:0] r;
        int unsigned base = a & ~32'd3;
        for (int b = 0; b < 4; b++)
            r[8*b +: 8] = model_mem.exists(base + b) ? model_mem[base + b] : 8'hxx;
        return r;
    endfunction

    task automatic do_reset();
        @(posedge clk); #1;
        rst    = 1'b1;
        htrans = 2'b00;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Single non-pipelined transfer; returns what the data phase looked like
    task automatic ahb_xfer(input op_t op, output obs_t o);
        int g;
        htrans = 2'b10;
        hwrite = op.w;
        hsize  = op.size;
        haddr  = op.addr;
        @(negedge clk);
        g = 0;
        while (hready !== 1'b1 && g < 64) begin
            @(negedge clk);
            g++;
        end
        @(posedge clk); #1;
        htrans = 2'b00;
        hwdata = op.wdata;
        @(negedge clk);
        o.resp_first = hresp;
        o.waits      = 0;
        while (hready !== 1'b1 && o.waits < 64) begin
            o.waits++;
            @(negedge clk);
        end
        o.data      = hrdata;
        o.resp_last = hresp;
        @(posedge clk); #1;
    endtask

    task automatic run_op(input op_t op, input int nwait, output obs_t o);
        exp_t e;
        e.err   = op.err;
        e.waits = op.err ? 1 : nwait;
        e.data  = (op.err || op.w) ? 32'h0 : model_read(op.addr);
        exp_q.push_back(e);
        ahb_xfer(op, o);
        if (!op.err && op.w) model_write(op.addr, op.size, op.wdata);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (hready !== 1'b1)    begin errors++; $display("FAIL reset_hready: got %b want 1", hready); end
        checks++; if (hresp !== 1'b0)     begin errors++; $display("FAIL reset_hresp: got %b want 0", hresp); end
        checks++; if (hrdata !== 32'h0)   begin errors++; $display("FAIL reset_hrdata: got %h want 0", hrdata); end
        checks++; if (txn_cnt !== 32'h0)  begin errors++; $display("FAIL reset_txn: got %0d want 0", txn_cnt); end
        checks++; if (err_cnt !== 16'h0)  begin errors++; $display("FAIL reset_err: got %0d want 0", err_cnt); end
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic test_idle_busy();
        htrans = 2'b01; hsize = 3'd2; haddr = 32'h2; hwrite = 1'b1;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (hready !== 1'b1 || hresp !== 1'b0) begin
                errors++; $display("FAIL busy_ignored: got hready=%b hresp=%b want 1 0", hready, hresp);
            end
            @(posedge clk); #1;
        end
        htrans = 2'b00;
        @(negedge clk);
        checks++;
        if (txn_cnt !== 32'h0 || err_cnt !== 16'h0) begin
            errors++; $display("FAIL busy_counts: got txn=%0d err=%0d want 0 0", txn_cnt, err_cnt);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        stall_mode = 2'd0;
        do_reset();
        htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2; haddr = 32'h10;
        @(negedge clk);
        checks++; if (hready !== 1'b1) begin errors++; $display("FAIL b2b_accept: got hready=%b want 1", hready); end
        @(posedge clk); #1;
        hwdata = 32'hDEAD_BEEF; hwrite = 1'b0;
        model_write(32'h10, 3'd2, 32'hDEAD_BEEF);
        exp_q.push_back('{model_read(32'h10), 0, 1'b0});
        @(negedge clk);
        checks++;
        if (hready !== 1'b1 || hresp !== 1'b0) begin
            errors++; $display("FAIL b2b_write_data: got hready=%b hresp=%b want 1 0", hready, hresp);
        end
        @(posedge clk); #1;
        htrans = 2'b00;
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if (hready !== 1'b1 || hrdata !== e.data) begin
            errors++; $display("FAIL b2b_read: got hready=%b data=%h want 1 %h", hready, hrdata, e.data);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (txn_cnt !== 32'd2) begin errors++; $display("FAIL b2b_txn: got %0d want 2", txn_cnt); end
        @(posedge clk); #1;
    endtask

    task automatic test_fixed_stall();
        obs_t o;
        exp_t e;
        stall_mode = 2'd0;
        run_op('{1'b1, 3'd2, 32'h20, 32'h7654_3210, 1'b0}, 0, o);
        void'(exp_q.pop_front());
        stall_mode = 2'd1; stall_cnt = 4'd3;
        fork
            begin
                repeat (2) @(posedge clk);
                #2 stall_cnt = 4'd9;
            end
        join_none
        run_op('{1'b0, 3'd2, 32'h20, 32'h0, 1'b0}, 3, o);
        e = exp_q.pop_front();
        checks++;
        if (o.data !== e.data || o.waits != e.waits || o.resp_first !== 1'b0 || o.resp_last !== 1'b0) begin
            errors++;
            $display("FAIL fixed_stall: got data=%h waits=%0d resp=%b%b want %h %0d 00",
                     o.data, o.waits, o.resp_first, o.resp_last, e.data, e.waits);
        end
        stall_mode = 2'd0; stall_cnt = 4'd0;
    endtask

    task automatic test_bytes();
        op_t  ops[$];
        obs_t o;
        exp_t e;
        stall_mode = 2'd0;
        ops.push_back('{1'b1, 3'd2, 32'h40, 32'h5566_7788, 1'b0});
        ops.push_back('{1'b1, 3'd0, 32'h41, 32'hFFFF_A5FF, 1'b0});
        ops.push_back('{1'b1, 3'd1, 32'h42, 32'h1234_EEEE, 1'b0});
        ops.push_back('{1'b0, 3'd2, 32'h40, 32'h0,         1'b0});
        ops.push_back('{1'b1, 3'd0, 32'h47, 32'h9A00_0000, 1'b0});
        ops.push_back('{1'b0, 3'd1, 32'h46, 32'h0,         1'b0});
        foreach (ops[k]) begin
            run_op(ops[k], 0, o);
            e = exp_q.pop_front();
            checks++;
            if (o.data !== e.data || o.waits != e.waits || o.resp_last !== 1'b0) begin
                errors++;
                $display("FAIL bytes[%0d]: got data=%h waits=%0d resp=%b want %h %0d 0",
                         k, o.data, o.waits, o.resp_last, e.data, e.waits);
            end
        end
        checks++;
        if (model_read(32'h40) !== 32'h1234_A588) begin
            errors++; $display("FAIL bytes_model: got %h want 1234a588", model_read(32'h40));
        end
    endtask

    task automatic test_errors();
        op_t  ops[$];
        obs_t o;
        exp_t e;
        stall_mode = 2'd0;
        do_reset();
        ops.push_back('{1'b1, 3'd2, 32'h0,     32'h0BAD_F00D, 1'b0});
        ops.push_back('{1'b0, 3'd2, 32'h2,     32'h0,         1'b1});
        ops.push_back('{1'b1, 3'd3, 32'h10,    32'h1111_2222, 1'b1});
        ops.push_back('{1'b1, 3'd2, 32'h10000, 32'h3333_4444, 1'b1});
        ops.push_back('{1'b0, 3'd2, 32'h0,     32'h0,         1'b0});
        ops.push_back('{1'b0, 3'd2, 32'h10,    32'h0,         1'b0});
        foreach (ops[k]) begin
            run_op(ops[k], 0, o);
            e = exp_q.pop_front();
            checks++;
            if (o.data !== e.data || o.waits != e.waits || o.resp_first !== e.err || o.resp_last !== e.err) begin
                errors++;
                $display("FAIL errors[%0d]: got data=%h waits=%0d resp=%b%b want %h %0d %b%b",
                         k, o.data, o.waits, o.resp_first, o.resp_last, e.data, e.waits, e.err, e.err);
            end
        end
        @(negedge clk);
        checks++; if (err_cnt !== 16'd3) begin errors++; $display("FAIL errors_cnt: got %0d want 3", err_cnt); end
        checks++; if (txn_cnt !== 32'd3) begin errors++; $display("FAIL errors_txn: got %0d want 3", txn_cnt); end
        @(posedge clk); #1;
    endtask

    task automatic test_err_window();
        op_t  ops[$];
        obs_t o;
        exp_t e;
        stall_mode = 2'd0;
        do_reset();
        ops.push_back('{1'b1, 3'd2, 32'hEFFC, 32'hAAAA_0001, 1'b0});
        ops.push_back('{1'b1, 3'd2, 32'hF100, 32'hBBBB_0002, 1'b0});
        ops.push_back('{1'b1, 3'd2, 32'hF000, 32'hCCCC_0003, 1'b1});
        ops.push_back('{1'b0, 3'd2, 32'hF0FC, 32'h0,         1'b1});
        ops.push_back('{1'b0, 3'd2, 32'hEFFC, 32'h0,         1'b0});
        ops.push_back('{1'b0, 3'd2, 32'hF100, 32'h0,         1'b0});
        foreach (ops[k]) begin
            run_op(ops[k], 0, o);
            e = exp_q.pop_front();
            checks++;
            if (o.data !== e.data || o.waits != e.waits || o.resp_first !== e.err || o.resp_last !== e.err) begin
                errors++;
                $display("FAIL errwin[%0d]: got data=%h waits=%0d resp=%b%b want %h %0d %b%b",
                         k, o.data, o.waits, o.resp_first, o.resp_last, e.data, e.waits, e.err, e.err);
            end
        end
        @(negedge clk);
        checks++; if (err_cnt !== 16'd2) begin errors++; $display("FAIL errwin_cnt: got %0d want 2", err_cnt); end
        @(posedge clk); #1;
    endtask

    task automatic random_pass(input int pass);
        obs_t o;
        exp_t e;
        stall_mode = 2'd2;
        stall_cnt  = 4'hF;
        do_reset();
        for (int i = 0; i < 200; i++) begin
            run_op('{1'b0, 3'd2, 32'h20, 32'h0, 1'b0}, 0, o);
            e = exp_q.pop_front();
            rand_seq[pass][i] = o.waits;
            checks++;
            if (o.data !== e.data || o.waits > 15 || o.resp_last !== 1'b0) begin
                errors++;
                $display("FAIL random[%0d.%0d]: got data=%h waits=%0d resp=%b want %h <=15 0",
                         pass, i, o.data, o.waits, o.resp_last, e.data);
            end
        end
        stall_mode = 2'd0;
        stall_cnt  = 4'd0;
    endtask

    task automatic test_random();
        int distinct_seen;
        int diffs;
        random_pass(0);
        random_pass(1);
        distinct_seen = 0;
        diffs = 0;
        for (int i = 1; i < 200; i++)
            if (rand_seq[0][i] != rand_seq[0][0]) distinct_seen = 1;
        for (int i = 0; i < 200; i++)
            if (rand_seq[0][i] != rand_seq[1][i]) diffs++;
        checks++; if (distinct_seen != 1) begin errors++; $display("FAIL random_distinct: got %0d want 1", distinct_seen); end
        checks++; if (diffs != 0) begin errors++; $display("FAIL random_repeat: got %0d differing want 0", diffs); end
    endtask

    task automatic test_reset_mid_wait();
        obs_t o;
        exp_t e;
        stall_mode = 2'd0;
        run_op('{1'b1, 3'd2, 32'h30, 32'h0102_0304, 1'b0}, 0, o);
        void'(exp_q.pop_front());
        stall_mode = 2'd1; stall_cnt = 4'd5;
        htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2; haddr = 32'h30;
        @(negedge clk);
        @(posedge clk); #1;
        htrans = 2'b00; hwdata = 32'hFFFF_0000;
        @(negedge clk);
        checks++; if (hready !== 1'b0) begin errors++; $display("FAIL midwait_stalled: got hready=%b want 0", hready); end
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (hready !== 1'b1 || hresp !== 1'b0 || hrdata !== 32'h0) begin
            errors++; $display("FAIL midwait_outputs: got hready=%b hresp=%b data=%h want 1 0 0", hready, hresp, hrdata);
        end
        checks++;
        if (txn_cnt !== 32'h0 || err_cnt !== 16'h0) begin
            errors++; $display("FAIL midwait_counts: got txn=%0d err=%0d want 0 0", txn_cnt, err_cnt);
        end
        @(posedge clk); #1 rst = 1'b0;
        stall_mode = 2'd0; stall_cnt = 4'd0;
        run_op('{1'b0, 3'd2, 32'h30, 32'h0, 1'b0}, 0, o);
        e = exp_q.pop_front();
        checks++;
        if (o.data !== e.data || o.waits != 0) begin
            errors++; $display("FAIL midwait_keep: got data=%h waits=%0d want %h 0", o.data, o.waits, e.data);
        end
    endtask

    initial begin
        stall_mode = 2'd0;
        stall_cnt  = 4'd0;
        htrans     = 2'b00;
        hsize      = 3'd2;
        haddr      = 32'h0;
        hwrite     = 1'b0;
        hwdata     = 32'h0;
        test_reset();
        test_idle_busy();
        test_back_to_back();
        test_fixed_stall();
        test_bytes();
        test_errors();
        test_err_window();
        test_random();
        test_reset_mid_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
